pipeline_sequencer: RTL and testbench

- Central run/stall/flush controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Owns start/halt sequencing, one-cycle load-use stalls, and squashing of wrong-path instructions when a branch or jump resolves in MEM.
- Drives per-stage enable/flush strobes to the PC, the IF/ID, ID/EX and EX/MEM pipeline registers, and the MEM/WB register.
- Replaces the single global enable.

---
 rtl/pipeline_sequencer_pkg.sv | 14 +
 rtl/pipeline_sequencer_hazard_detect.sv | 24 ++
 rtl/pipeline_sequencer.sv | 129 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the 5-stage pipeline run/stall/flush sequencer.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam logic [4:0]  REG_ZERO             = 5'd0;
  localparam int unsigned DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational decode of MEM-stage redirects and EX->ID load-use hazards.
module hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       mem_branch,
  input  logic       mem_zero,
  input  logic       mem_jump,
  output logic       stall_req,
  output logic       redirect
);

  always_comb begin
    redirect  = mem_jump | (mem_branch & mem_zero);
    // $0 is hardwired, so a load targeting it never produces a dependency
    stall_req = ex_mem_read & (ex_rt != REG_ZERO) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/stall/flush controller: start/halt FSM, per-stage enable/flush strobes, event counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_t    state;
  logic [DW-1:0] drain_cnt;
  logic          stall_req;
  logic          redirect;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .mem_branch  (mem_branch),
    .mem_zero    (mem_zero),
    .mem_jump    (mem_jump),
    .stall_req   (stall_req),
    .redirect    (redirect)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
          end else if (stall_req) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
          end
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        HALTED: begin
          if (start) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the registered state plus same-cycle hazard decode
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b0;
    case (state)
      RUN: begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        mem_wb_en = 1'b1;
        if (redirect) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (stall_req) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      DRAIN: begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        mem_wb_en   = 1'b1;
        if (redirect) begin
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end
      end
      default: ;
    endcase
    running = (state == RUN);
    halted  = (state == HALTED);
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: RUN-mode hazard vector table plus halt/drain/reset sequences.
module tb_pipeline_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             arst_n;
  logic             start;
  logic             halt_req;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_jump;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .halt_req     (halt_req),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_branch   (mem_branch),
    .mem_zero     (mem_zero),
    .mem_jump     (mem_jump),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_en    (mem_wb_en),
    .running      (running),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, mem_wb_en}
  localparam logic [6:0] CTL_OFF   = 7'b0000000;
  localparam logic [6:0] CTL_RUN   = 7'b1101001;
  localparam logic [6:0] CTL_STALL = 7'b0001101;
  localparam logic [6:0] CTL_REDIR = 7'b1111111;
  localparam logic [6:0] CTL_DRAIN = 7'b0111001;
  localparam logic [6:0] CTL_DRRED = 7'b0111111;

  wire [6:0] ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, mem_wb_en};

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mrd;
    logic [4:0] xrt;
    logic       br;
    logic       zero;
    logic       jmp;
    logic [6:0] exp_ctl;
    int         stall_inc;
    int         flush_inc;
  } vec_t;

  vec_t vecs[12];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_stall;
  int   exp_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_haz(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mrd, input logic [4:0] xrt,
                         input logic br, input logic zero, input logic jmp);
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = uses_rt;
    ex_mem_read = mrd;
    ex_rt       = xrt;
    mem_branch  = br;
    mem_zero    = zero;
    mem_jump    = jmp;
    #1;
  endtask

  task automatic clear_haz();
    set_haz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"nop",            5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[1]  = '{"lu_rs",          5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, CTL_STALL, 1, 0};
    vecs[2]  = '{"lu_gone",        5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[3]  = '{"lu_r0_rs",       5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[4]  = '{"lu_rt_unused",   5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[5]  = '{"lu_rt_used",     5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, CTL_STALL, 1, 0};
    vecs[6]  = '{"br_taken_lu",    5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, CTL_REDIR, 0, 1};
    vecs[7]  = '{"br_not_taken",   5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[8]  = '{"jump",           5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, CTL_REDIR, 0, 1};
    vecs[9]  = '{"zero_no_branch", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, CTL_RUN,   0, 0};
    vecs[10] = '{"lu_r0_rt",       5'd4, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};
    vecs[11] = '{"lu_no_match",    5'd6, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, CTL_RUN,   0, 0};

    start    = 1'b0;
    halt_req = 1'b0;
    clear_haz();
    do_reset();

    check("reset_ctl", 32'(ctl), 32'(CTL_OFF));
    check("reset_running", 32'(running), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);

    // halt_req is ignored while IDLE; hazards produce no strobes either
    halt_req = 1'b1;
    set_haz(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    check("idle_ctl", 32'(ctl), 32'(CTL_OFF));
    tick();
    halt_req = 1'b0;
    clear_haz();
    check("idle_halt_ignored", 32'({running, halted}), 32'd0);
    check("idle_no_flush_cnt", 32'(flush_cnt), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("start_running", 32'(running), 32'd1);
    check("start_ctl", 32'(ctl), 32'(CTL_RUN));
    check("start_stall_cnt", 32'(stall_cnt), 32'd0);
    check("start_flush_cnt", 32'(flush_cnt), 32'd0);

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      set_haz(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mrd, vecs[i].xrt,
              vecs[i].br, vecs[i].zero, vecs[i].jmp);
      check({vecs[i].name, "_ctl"}, 32'(ctl), 32'(vecs[i].exp_ctl));
      tick();
      exp_stall += vecs[i].stall_inc;
      exp_flush += vecs[i].flush_inc;
      check({vecs[i].name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      check({vecs[i].name, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
      check({vecs[i].name, "_running"}, 32'(running), 32'd1);
    end
    clear_haz();

    // start and halt_req together in RUN: halt wins
    start    = 1'b1;
    halt_req = 1'b1;
    #1;
    check("halt_cycle_ctl", 32'(ctl), 32'(CTL_RUN));
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_haz(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      else if (c == 2) set_haz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      else clear_haz();
      check($sformatf("drain%0d_ctl", c), 32'(ctl),
            32'((c == 2) ? CTL_DRRED : CTL_DRAIN));
      check($sformatf("drain%0d_state", c), 32'({running, halted}), 32'd0);
      tick();
    end
    clear_haz();
    check("drain_no_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("halted_flag", 32'({running, halted}), 32'b01);
    check("halted_ctl", 32'(ctl), 32'(CTL_OFF));
    tick();
    check("halted_hold", 32'(halted), 32'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("resume_running", 32'({running, halted}), 32'b10);
    check("resume_ctl", 32'(ctl), 32'(CTL_RUN));

    // Fresh run: redirect plus load-use counts only as a flush
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    set_haz(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    check("both_ctl", 32'(ctl), 32'(CTL_REDIR));
    tick();
    check("both_flush_cnt", 32'(flush_cnt), 32'd1);
    check("both_stall_cnt", 32'(stall_cnt), 32'd0);
    set_haz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    clear_haz();
    check("three_flushes", 32'(flush_cnt), 32'd3);

    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    #1;
    check("drain_entry_ctl", 32'(ctl), 32'(CTL_DRAIN));
    arst_n = 1'b0;
    tick();
    check("mid_reset_ctl", 32'(ctl), 32'(CTL_OFF));
    check("mid_reset_state", 32'({running, halted}), 32'd0);
    check("mid_reset_flush_cnt", 32'(flush_cnt), 32'd0);
    check("mid_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    arst_n = 1'b1;
    tick();
    tick();
    check("idle_after_reset", 32'({running, halted}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
